// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined MIPS shifter.
// ROT decode is acted on only when PIPELINED_SHIFTER_ROTATE_EN is defined.
package shifter_pkg;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2,
      SH_ROT = 2'd3
   } shift_op_e;

   // Only funct[1:0] selects the operation; funct[2] picks the amount source in the top.
   function automatic shift_op_e decode_funct(input logic [5:0] funct);
      shift_op_e op;
      case (funct[1:0])
         2'b00:   op = SH_SLL;
         2'b10:   op = SH_SRL;
         2'b11:   op = SH_SRA;
         default: op = SH_ROT;
      endcase
      return op;
   endfunction

   // Lowest amount bit owned by stage k; stage k owns [lo(k), lo(k+1)).
   function automatic int unsigned stage_lo_bit(input int unsigned k,
                                                input int unsigned sa_w,
                                                input int unsigned stages);
      int unsigned per;
      per = (sa_w + stages - 1) / stages;
      if (k >= stages || k * per > sa_w) return sa_w;
      return k * per;
   endfunction

endpackage

// File: rtl/shifter_stage.sv
// One register slice of the pipelined shifter: partial barrel over owned amount bits.
// PIPELINED_SHIFTER_ROTATE_EN enables rotate-right for the ROT op; otherwise ROT passes data through.
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SA_W  = 5,
   parameter int unsigned LO    = 0,
   parameter int unsigned HI    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready_c,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SA_W-1:0]  in_amt,
   input  logic [1:0]       in_op,
   input  logic             in_sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SA_W-1:0]  out_amt,
   output logic [1:0]       out_op,
   output logic             out_sign
);

   localparam logic [SA_W-1:0] OWN_MASK = SA_W'(((1 << HI) - 1) & ~((1 << LO) - 1));

   logic [SA_W-1:0]  amt_own_c;
   logic [WIDTH-1:0] shifted_c;

   // Partial barrel: shifting by the masked amount equals the sum of owned 2^i terms.
   always_comb begin
      amt_own_c = in_amt & OWN_MASK;
      shifted_c = in_data;
      case (shift_op_e'(in_op))
         SH_SLL:  shifted_c = in_data << amt_own_c;
         SH_SRL:  shifted_c = in_data >> amt_own_c;
         SH_SRA:  shifted_c = WIDTH'($signed({in_sign, in_data}) >>> amt_own_c);
         default: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            shifted_c = WIDTH'({in_data, in_data} >> amt_own_c);
`else
            shifted_c = in_data;
`endif
         end
      endcase
   end

   assign in_ready_c = !out_valid || out_ready;

   // Data only moves on a real transfer so a stalled output stays stable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_amt   <= '0;
         out_op    <= 2'b00;
         out_sign  <= 1'b0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (in_ready_c)
            out_valid <= in_valid;
         if (in_ready_c && in_valid && !flush) begin
            out_data <= shifted_c;
            out_amt  <= in_amt & ~OWN_MASK;
            out_op   <= in_op;
            out_sign <= in_sign;
         end
      end
   end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined MIPS SLL/SRL/SRA(V) shifter with valid/ready handshake and synchronous flush.
// Define PIPELINED_SHIFTER_ROTATE_EN to make funct[1:0]=01 a rotate right.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned SA_W   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       funct,
   input  logic [SA_W-1:0]  shamt,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] shift_out
);

   // Index 0 is the issue side, index STAGES is the result register.
   logic             v_s   [STAGES+1];
   logic             rdy_s [STAGES+1];
   logic [WIDTH-1:0] d_s   [STAGES+1];
   logic [SA_W-1:0]  a_s   [STAGES+1];
   logic [1:0]       op_s  [STAGES+1];
   logic             sg_s  [STAGES+1];

   assign v_s[0]        = in_valid && !flush;
   assign d_s[0]        = op2;
   assign a_s[0]        = funct[2] ? op1[SA_W-1:0] : shamt;
   assign op_s[0]       = 2'(decode_funct(funct));
   assign sg_s[0]       = op2[WIDTH-1];
   assign rdy_s[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      shifter_stage #(
         .WIDTH (WIDTH),
         .SA_W  (SA_W),
         .LO    (stage_lo_bit(k, SA_W, STAGES)),
         .HI    (stage_lo_bit(k + 1, SA_W, STAGES))
      ) u_stage (
         .clk        (clk),
         .reset      (reset),
         .flush      (flush),
         .in_valid   (v_s[k]),
         .in_ready_c (rdy_s[k]),
         .in_data    (d_s[k]),
         .in_amt     (a_s[k]),
         .in_op      (op_s[k]),
         .in_sign    (sg_s[k]),
         .out_valid  (v_s[k+1]),
         .out_ready  (rdy_s[k+1]),
         .out_data   (d_s[k+1]),
         .out_amt    (a_s[k+1]),
         .out_op     (op_s[k+1]),
         .out_sign   (sg_s[k+1])
      );
   end

   assign in_ready  = rdy_s[0] && !flush;
   assign out_valid = v_s[STAGES];
   assign shift_out = d_s[STAGES];

   // Upper op1 bits are ignored (modulo amount); tail sidebands have no consumer.
   logic unused_bits;
   assign unused_bits = ^{op1[WIDTH-1:SA_W], funct[5:3], a_s[STAGES], op_s[STAGES], sg_s[STAGES]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=32, STAGES=2).
module tb_pipelined_shifter;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 2;
   localparam int unsigned SA_W   = 5;

   logic             clk = 1'b0;
   logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [5:0]       funct;
   logic [SA_W-1:0]  shamt;
   logic [WIDTH-1:0] op1, op2, shift_out;

   pipelined_shifter #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .funct     (funct),
      .shamt     (shamt),
      .op1       (op1),
      .op2       (op2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .shift_out (shift_out)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          n_pop = 0;
   logic [31:0] exp_q[$];
   int          pop_cyc[$];
   logic        prev_hold = 1'b0;
   logic        prev_flush = 1'b0;
   logic [31:0] prev_out = '0;
   logic [31:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: pops expectations on each output transfer and checks stall stability.
   always @(negedge clk) begin
      if (!reset) begin
         if (prev_hold && !prev_flush) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", shift_out, prev_out);
         end
         if (out_valid && out_ready) begin
            n_pop++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0)
               check("unexpected_out_valid", 32'(out_valid), 32'd0);
            else begin
               mon_exp = exp_q.pop_front();
               check("result", shift_out, mon_exp);
            end
         end
         prev_hold  = out_valid && !out_ready;
         prev_out   = shift_out;
         prev_flush = flush;
      end else begin
         prev_hold  = 1'b0;
         prev_flush = 1'b0;
      end
   end

   task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, output int iters);
      bit done;
      done     = 1'b0;
      iters    = 0;
      in_valid = 1'b1;
      funct    = f;
      shamt    = sh;
      op1      = a;
      op2      = b;
      while (!done && iters < 50) begin
         @(negedge clk);
         iters++;
         if (in_ready) begin
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_left", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   it, lat, acc, j, n0, sum;
      logic got;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      funct = '0; shamt = '0; op1 = '0; op2 = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_shift_out", shift_out, 32'd0);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // SLL by 31 and its latency
      send(6'h00, 5'd31, 32'h0, 32'h0000_0001, 32'h8000_0000, it);
      lat = 0; got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid) got = 1'b1;
      end
      check("sll_latency", 32'(lat), 32'(STAGES));
      wait_drain();

      // Variable and immediate forms, amount-0 and upper-op1-ignored cases
      send(6'h07, 5'd0,  32'hFFFF_FFE4, 32'h8000_0000, 32'hF800_0000, it);
      send(6'h06, 5'd0,  32'hFFFF_FFE4, 32'h8000_0000, 32'h0800_0000, it);
      send(6'h03, 5'd31, 32'h0,         32'h8000_0000, 32'hFFFF_FFFF, it);
      send(6'h03, 5'd8,  32'h0,         32'h7F00_0000, 32'h007F_0000, it);
      send(6'h04, 5'd0,  32'h0000_0023, 32'h0000_0001, 32'h0000_0008, it);
      send(6'h00, 5'd0,  32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, it);
      send(6'h07, 5'd9,  32'h0000_0020, 32'h8000_0001, 32'h8000_0001, it);
      wait_drain();

      // Back-to-back SRL stream
      pop_cyc.delete();
      sum = 0;
      for (int i = 0; i < 8; i++) begin
         send(6'h02, 5'(i), 32'h0, 32'hFF00_0000, 32'hFF00_0000 >> i, it);
         sum += it;
      end
      check("stream_accept_cycles", 32'(sum), 32'd8);
      wait_drain();
      check("stream_out_count", 32'(pop_cyc.size()), 32'd8);
      if (pop_cyc.size() >= 8)
         check("stream_out_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

      // Output stall: pipeline fills to STAGES then in_ready drops
      out_ready = 1'b0;
      acc = 0; j = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         funct    = 6'h00;
         shamt    = 5'(j + 1);
         op1      = 32'h0;
         op2      = 32'h0000_0001;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(32'h1 << (j + 1));
            acc++;
            j++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stall_accepted", 32'(acc), 32'(STAGES));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      n0 = n_pop;
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain();
      check("stall_drained", 32'(n_pop - n0), 32'(STAGES));
      repeat (2) @(negedge clk);
      check("after_drain_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Flush with two ops in flight
      out_ready = 1'b0;
      send(6'h00, 5'd1, 32'h0, 32'h1, 32'h2, it);
      send(6'h00, 5'd2, 32'h0, 32'h1, 32'h4, it);
      flush    = 1'b1;
      in_valid = 1'b1;
      shamt    = 5'd3;
      @(negedge clk);
      check("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("flush_dropped", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      send(6'h02, 5'd4, 32'h0, 32'h0000_00F0, 32'h0000_000F, it);
      send(6'h02, 5'd1, 32'h0, 32'h0000_00F0, 32'h0000_0078, it);
      @(negedge clk);
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      check("reset_async_valid", 32'(out_valid), 32'd0);
      check("reset_async_data", shift_out, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", 32'(in_ready), 32'd1);
      check("post_reset_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      // funct[1:0]=01: rotate when enabled, pass-through otherwise
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      send(6'h01, 5'd4, 32'h0, 32'h0000_00F1, 32'h1000_000F, it);
`else
      send(6'h01, 5'd4, 32'h0, 32'h0000_00F1, 32'h0000_00F1, it);
`endif
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
